// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_nibble_adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_nibble_adder_adder_4bit.sv
// Combinational 4-bit ripple adder used for one nibble per cycle.
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial adder: one 4-bit slice per cycle, {cout,sum} = a+b+cin.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_nibble_adder
   import serial_nibble_adder_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                    cin,
   output logic                    busy,
   output logic                    done,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                    cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic                    ovf
`endif
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
   logic                nib_cout;

   assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
   assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

   adder_4bit u_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   // Carry into the MSB is recovered as a^b^s of that bit.
   logic msb_carry_in;
   assign msb_carry_in = nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1];
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
            carry_d = nib_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = nib_cout;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = msb_carry_in ^ nib_cout;
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
